// File: rtl/fifo_buf.sv
// ---------------------------------------------------------------------------
// fifo_buf -- parametrised single-clock elastic buffer
//
// General-purpose FIFO between the J1 core bus masters and the
// cache/peripheral side. Supports any depth (not only powers of two), an
// exact occupancy count, programmable almost-full/almost-empty thresholds,
// a registered or first-word-fall-through read port, a synchronous flush,
// and sticky overflow/underflow error flags.
//
// Parameters
//   BIT_WIDTH  data word width in bits (>= 1)
//   MEM_SIZE   depth in words (>= 2, any integer)
//   AFULL_TH   almost_full asserted when count >= AFULL_TH
//   AEMPTY_TH  almost_empty asserted when count <= AEMPTY_TH
//   FWFT       0 = registered read (dout one cycle after rd)
//              1 = first-word-fall-through (rd pops the visible word)
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   clr           synchronous flush, active-high (wins over wr/rd)
//   wr, din       write request and write data
//   rd            read request (FWFT: pop/acknowledge of the visible word)
//   dout          read data
//   dout_valid    dout holds valid data
//   full, empty   count == MEM_SIZE / count == 0
//   almost_full   count >= AFULL_TH
//   almost_empty  count <= AEMPTY_TH
//   count         number of words stored
//   overflow      sticky: write attempted while full and not accepted
//   underflow     sticky: read attempted while empty and not accepted
// ---------------------------------------------------------------------------
module fifo_buf #(
    parameter int BIT_WIDTH = 8,
    parameter int MEM_SIZE  = 256,
    parameter int AFULL_TH  = MEM_SIZE - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             wr,
    input  logic [BIT_WIDTH-1:0]             din,
    input  logic                             rd,
    output logic [BIT_WIDTH-1:0]             dout,
    output logic                             dout_valid,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic [$clog2(MEM_SIZE+1)-1:0]    count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int CNT_W = $clog2(MEM_SIZE + 1);
    localparam int PTR_W = $clog2(MEM_SIZE);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_SIZE);

    // Storage is deliberately not reset.
    logic [BIT_WIDTH-1:0] mem [MEM_SIZE];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic wr_ok;
    logic rd_ok;

    // Pointer wrap uses an explicit compare so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // Status decode: all flags come from the registered count, so they show
    // the state after the most recent edge.
    // -----------------------------------------------------------------------
    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign almost_full  = (32'(count) >= AFULL_TH);
    assign almost_empty = (32'(count) <= AEMPTY_TH);

    // A read frees a slot in the same cycle, so a write into a full FIFO is
    // accepted when paired with a successful read. A flush cycle accepts
    // nothing and raises no error.
    assign rd_ok = rd & ~clr & ~empty;
    assign wr_ok = wr & ~clr & (~full | rd_ok);

    // -----------------------------------------------------------------------
    // Stage p0 -> state: pointers, count, sticky error flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (rd_ok) begin
                head <= ptr_inc(head);
            end
            if (wr_ok) begin
                tail <= ptr_inc(tail);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr & ~wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd & ~rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[tail] <= din;
        end
    end

    // -----------------------------------------------------------------------
    // Read port
    // -----------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is always presented; an empty FIFO shows zero so
            // stale storage never leaks onto the bus.
            assign dout       = empty ? '0 : mem[head];
            assign dout_valid = ~empty;
        end else begin : g_reg
            logic [BIT_WIDTH-1:0] dout_p1;
            logic                 vld_p1;

            // ---------------------------------------------------------------
            // Stage p0 -> p1: registered read, one cycle after rd
            // ---------------------------------------------------------------
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_p1 <= '0;
                    vld_p1  <= 1'b0;
                end else if (clr) begin
                    vld_p1  <= 1'b0;
                end else if (rd_ok) begin
                    dout_p1 <= mem[head];
                    vld_p1  <= 1'b1;
                end else begin
                    // Data holds its last value; only the valid bit drops.
                    vld_p1  <= 1'b0;
                end
            end

            assign dout       = dout_p1;
            assign dout_valid = vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_buf.sv
module tb_fifo_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] din = 8'h00;

    always #5 clk = ~clk;

    // Instance A: depth 5, registered read, default thresholds (AFULL_TH=3)
    logic [7:0] a_dout;
    logic       a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_count;

    fifo_buf #(.BIT_WIDTH(8), .MEM_SIZE(5), .AEMPTY_TH(2), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .din(din), .rd(rd),
        .dout(a_dout), .dout_valid(a_valid), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf)
    );

    // Instance B: depth 8, thresholds 6 / 2
    logic [7:0] b_dout;
    logic       b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [3:0] b_count;

    fifo_buf #(.BIT_WIDTH(8), .MEM_SIZE(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .din(din), .rd(rd),
        .dout(b_dout), .dout_valid(b_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf)
    );

    // Instance C: depth 4, first-word-fall-through
    logic [7:0] c_dout;
    logic       c_valid, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [2:0] c_count;

    fifo_buf #(.BIT_WIDTH(8), .MEM_SIZE(4), .FWFT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .din(din), .rd(rd),
        .dout(c_dout), .dout_valid(c_valid), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .count(c_count),
        .overflow(c_ovf), .underflow(c_udf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic w, input logic r, input logic c, input logic [7:0] d);
        wr  = w;
        rd  = r;
        clr = c;
        din = d;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       wr, rd, clr;
        logic [7:0] din;
        logic       chk_dout;
        logic [7:0] dout;
        logic       valid;
        logic [2:0] count;
        logic       full, empty, ovf, udf;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic w, input logic r, input logic c, input logic [7:0] d,
                              input logic cd, input logic [7:0] od, input logic ov,
                              input logic [2:0] cnt, input logic f, input logic e,
                              input logic ovf, input logic udf);
        vec_t x;
        x.wr = w; x.rd = r; x.clr = c; x.din = d;
        x.chk_dout = cd; x.dout = od; x.valid = ov; x.count = cnt;
        x.full = f; x.empty = e; x.ovf = ovf; x.udf = udf;
        vecs.push_back(x);
    endfunction

    initial begin
        // Instance A vectors: wr rd clr din | chk dout valid count full empty ovf udf
        v(1,0,0,8'h11, 1,8'h00,0, 3'd1, 0,0,0,0);
        v(1,0,0,8'h22, 1,8'h00,0, 3'd2, 0,0,0,0);
        v(1,0,0,8'h33, 1,8'h00,0, 3'd3, 0,0,0,0);
        v(0,1,0,8'h00, 1,8'h11,1, 3'd2, 0,0,0,0);
        v(0,1,0,8'h00, 1,8'h22,1, 3'd1, 0,0,0,0);
        v(0,1,0,8'h00, 1,8'h33,1, 3'd0, 0,1,0,0);
        v(0,0,0,8'h00, 1,8'h33,0, 3'd0, 0,1,0,0);
        // empty with wr&rd: write taken, read refused
        v(1,1,0,8'hA5, 1,8'h33,0, 3'd1, 0,0,0,1);
        v(1,0,0,8'h01, 1,8'h33,0, 3'd2, 0,0,0,1);
        v(1,0,0,8'h02, 1,8'h33,0, 3'd3, 0,0,0,1);
        v(1,0,0,8'h03, 1,8'h33,0, 3'd4, 0,0,0,1);
        v(1,0,0,8'h04, 1,8'h33,0, 3'd5, 1,0,0,1);
        // write into full FIFO is dropped
        v(1,0,0,8'h99, 1,8'h33,0, 3'd5, 1,0,1,1);
        // full with wr&rd: oldest out, new word stored last
        v(1,1,0,8'h05, 1,8'hA5,1, 3'd5, 1,0,1,1);
        v(0,1,0,8'h00, 1,8'h01,1, 3'd4, 0,0,1,1);
        v(0,1,0,8'h00, 1,8'h02,1, 3'd3, 0,0,1,1);
        v(0,1,0,8'h00, 1,8'h03,1, 3'd2, 0,0,1,1);
        v(0,1,0,8'h00, 1,8'h04,1, 3'd1, 0,0,1,1);
        v(0,1,0,8'h00, 1,8'h05,1, 3'd0, 0,1,1,1);
        // flush clears flags and pointers
        v(0,0,1,8'h00, 0,8'h00,0, 3'd0, 0,1,0,0);
        // second fill/drain pass
        v(1,0,0,8'h06, 0,8'h00,0, 3'd1, 0,0,0,0);
        v(1,0,0,8'h07, 0,8'h00,0, 3'd2, 0,0,0,0);
        v(1,0,0,8'h08, 0,8'h00,0, 3'd3, 0,0,0,0);
        v(1,0,0,8'h09, 0,8'h00,0, 3'd4, 0,0,0,0);
        v(1,0,0,8'h0A, 0,8'h00,0, 3'd5, 1,0,0,0);
        v(1,0,0,8'hEE, 0,8'h00,0, 3'd5, 1,0,1,0);
        v(0,1,0,8'h00, 1,8'h06,1, 3'd4, 0,0,1,0);
        // mid-stream flush with a write pending: write discarded
        v(1,0,1,8'h77, 0,8'h00,0, 3'd0, 0,1,0,0);
        v(0,0,0,8'h00, 0,8'h00,0, 3'd0, 0,1,0,0);
        v(1,0,0,8'h12, 0,8'h00,0, 3'd1, 0,0,0,0);
        v(0,1,0,8'h00, 1,8'h12,1, 3'd0, 0,1,0,0);
        v(0,1,0,8'h00, 1,8'h12,0, 3'd0, 0,1,0,1);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst a.count", 32'(a_count), 0);
        chk("rst a.empty", 32'(a_empty), 1);
        chk("rst a.full",  32'(a_full), 0);
        chk("rst a.dout",  32'(a_dout), 0);
        chk("rst a.valid", 32'(a_valid), 0);
        chk("rst a.ovf",   32'(a_ovf), 0);
        chk("rst a.udf",   32'(a_udf), 0);
        chk("rst a.ae",    32'(a_ae), 1);
        chk("rst a.af",    32'(a_af), 0);
        rst_n = 1'b1;

        // ---------------- table-driven run on instance A ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            step();
            chk($sformatf("row%0d count", i), 32'(a_count), 32'(vecs[i].count));
            chk($sformatf("row%0d full", i),  32'(a_full),  32'(vecs[i].full));
            chk($sformatf("row%0d empty", i), 32'(a_empty), 32'(vecs[i].empty));
            chk($sformatf("row%0d valid", i), 32'(a_valid), 32'(vecs[i].valid));
            chk($sformatf("row%0d ovf", i),   32'(a_ovf),   32'(vecs[i].ovf));
            chk($sformatf("row%0d udf", i),   32'(a_udf),   32'(vecs[i].udf));
            chk($sformatf("row%0d af", i),    32'(a_af),    32'(vecs[i].count >= 3'd3));
            chk($sformatf("row%0d ae", i),    32'(a_ae),    32'(vecs[i].count <= 3'd2));
            if (vecs[i].chk_dout) begin
                chk($sformatf("row%0d dout", i), 32'(a_dout), 32'(vecs[i].dout));
            end
        end

        // ---------------- thresholds on instance B ----------------
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            chk($sformatf("thr%0d count", i), 32'(b_count), i);
            chk($sformatf("thr%0d ae", i),    32'(b_ae), (i <= 2) ? 1 : 0);
            chk($sformatf("thr%0d af", i),    32'(b_af), (i >= 6) ? 1 : 0);
            chk($sformatf("thr%0d full", i),  32'(b_full), (i == 8) ? 1 : 0);
            if (i < 8) begin
                set_in(1'b1, 1'b0, 1'b0, 8'(i));
                step();
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset pulse mid-cycle while B is full
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst b.count", 32'(b_count), 0);
        chk("arst b.full",  32'(b_full), 0);
        chk("arst b.empty", 32'(b_empty), 1);
        chk("arst b.ae",    32'(b_ae), 1);
        chk("arst b.af",    32'(b_af), 0);
        #1;
        rst_n = 1'b1;

        // ---------------- FWFT on instance C ----------------
        step();
        do_reset();
        chk("fwft rst dout",  32'(c_dout), 0);
        chk("fwft rst valid", 32'(c_valid), 0);
        set_in(1'b1, 1'b0, 1'b0, 8'h5A);
        step();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fwft wr dout",  32'(c_dout), 32'h5A);
        chk("fwft wr valid", 32'(c_valid), 1);
        chk("fwft wr count", 32'(c_count), 1);
        step();
        chk("fwft hold dout", 32'(c_dout), 32'h5A);
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fwft pop empty", 32'(c_empty), 1);
        chk("fwft pop valid", 32'(c_valid), 0);
        chk("fwft pop dout",  32'(c_dout), 0);
        set_in(1'b1, 1'b0, 1'b0, 8'h61);
        step();
        set_in(1'b1, 1'b0, 1'b0, 8'h62);
        step();
        chk("fwft two dout",  32'(c_dout), 32'h61);
        chk("fwft two count", 32'(c_count), 2);
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        chk("fwft next dout", 32'(c_dout), 32'h62);
        set_in(1'b1, 1'b1, 1'b0, 8'h63);
        step();
        chk("fwft wr+rd dout",  32'(c_dout), 32'h63);
        chk("fwft wr+rd count", 32'(c_count), 1);
        set_in(1'b1, 1'b0, 1'b0, 8'h64);
        step();
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fwft wrap dout", 32'(c_dout), 32'h64);
        chk("fwft wrap udf",  32'(c_udf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_buf.md
Name: fifo_buf

Overview:
- Parametrised successor to the single-clock byte FIFO.
- Adds configurable width and any depth (not only powers of two), a correct full/empty count, and programmable almost-full/almost-empty thresholds.
- Selectable read mode: registered or first-word-fall-through. Also adds a synchronous flush and sticky overflow/underflow error flags.
- Sits between J1 core bus masters and the cache/peripheral side as the general-purpose elastic buffer.

Parameters:
- BIT_WIDTH, 8: data word width in bits (>=1).
- MEM_SIZE, 256: depth in words (>=2, any integer).
- AFULL_TH, MEM_SIZE-2: almost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserted when count <= AEMPTY_TH.
- FWFT, 0: 0 = registered read (data one cycle after rd); 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush, active-high
- wr  in  1  write request
- din  in  BIT_WIDTH  write data
- rd  in  1  read request (FWFT: pop/acknowledge)
- dout  out  BIT_WIDTH  read data
- dout_valid  out  1  dout holds valid data
- full  out  1  count == MEM_SIZE
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_TH
- almost_empty  out  1  count <= AEMPTY_TH
- count  out  $clog2(MEM_SIZE+1)  words stored
- overflow  out  1  sticky: wr attempted while full and not accepted
- underflow  out  1  sticky: rd attempted while empty and not accepted

Behaviour:
- Reset (rst_n low, async): head=tail=count=0; dout=0, dout_valid=0, overflow=underflow=0; empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0). Memory contents are not reset.
- Acceptance: wr_ok = wr & (!full | rd_ok); rd_ok = rd & !empty.
  - Full with wr & rd: both accepted; count unchanged.
  - Empty with wr & rd: write accepted, read rejected; count +1, underflow set.
- Pointers: head/tail advance by 1 on rd_ok/wr_ok and wrap from MEM_SIZE-1 to 0 (explicit compare, no power-of-two assumption).
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Width is sufficient to hold MEM_SIZE.
- Write: mem[tail] <= din on wr_ok.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from registered count, so they reflect state after the last edge.
- FWFT=0:
  - On rd_ok, dout <= mem[head] and dout_valid <= 1 at the next edge (latency 1).
  - Cycle without rd_ok: dout_valid <= 0 and dout holds its last value.
- FWFT=1:
  - dout = mem[head] combinationally; dout_valid = !empty.
  - When empty, dout = 0.
  - rd_ok pops; the next word appears after that edge.
  - A word written into an empty FIFO is visible the cycle after the write.
- Errors: overflow <= 1 on wr & !wr_ok; underflow <= 1 on rd & !rd_ok. Both are cleared only by reset or clr.
- clr: highest priority below reset. Next edge sets head=tail=count=0, dout_valid=0, overflow=underflow=0. wr/rd in the same cycle are ignored; no error flags are raised.
- Reset mid-operation: immediate return to reset state; no partial pointer update.

Test Plan:
- Reset, then write 0x11,0x22,0x33 (FWFT=0), then 3 reads -> dout 0x11,0x22,0x33 each one cycle after rd with dout_valid=1; count 3->0; empty=1 at end.
- MEM_SIZE=5, fill with 5 writes -> full=1, count=5. A 6th wr -> ignored, overflow=1. Then 5 reads -> data in order, with tail/head wrap verified across two fill/drain passes.
- Empty FIFO, wr=rd=1 with din=0xA5 -> count=1, underflow=1. Full FIFO, wr=rd=1 -> count stays MEM_SIZE, oldest word out, new word stored last, no overflow.
- AFULL_TH=6, AEMPTY_TH=2, MEM_SIZE=8: increment count 0..8 -> almost_empty high for 0..2, almost_full high for 6..8.
- FWFT=1: write 0x5A into empty FIFO -> next cycle dout=0x5A, dout_valid=1 with no rd. Then rd -> empty=1, dout_valid=0, dout=0.
- Mid-stream clr with wr=1 (count=4, overflow=1) -> next cycle count=0, empty=1, overflow=0, write discarded. Async rst_n pulse mid-cycle -> outputs at reset values before the next edge.
